// File: rtl/uart_pkg.sv
// Shared UART definitions: line FSM encoding, default rates and bit-timing helpers.
// Used by both the transmit and receive sides of the 32-bit link.
package uart_pkg;

    localparam int DEF_CLK_FREQ  = 50_000_000;
    localparam int DEF_BAUD_RATE = 115_200;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_GAP   = 3'd4
    } uart_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Single 8N1 byte serialiser. A start coinciding with o_done chains the next
// frame directly after the stop bit with no idle time.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       i_start,
    input  logic [7:0] i_data,
    output logic       o_txd,
    output logic       o_busy,
    output logic       o_done
);

    localparam int            CW        = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    uart_state_t   r_state;
    uart_state_t   w_state_next;
    logic [CW-1:0] r_baud_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_data;
    logic          r_txd;
    logic          w_txd_next;
    logic          w_bit_end;
    logic          w_go;

    assign w_bit_end = (r_baud_cnt == BAUD_LAST);
    assign o_done    = (r_state == ST_STOP) && w_bit_end;
    assign o_busy    = (r_state != ST_IDLE);
    assign o_txd     = r_txd;
    assign w_go      = i_start && ((r_state == ST_IDLE) || o_done);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state    <= ST_IDLE;
            r_txd      <= 1'b1;
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_data     <= 8'h00;
        end else begin
            r_state <= w_state_next;
            r_txd   <= w_txd_next;
            if (w_go) begin
                r_data     <= i_data;
                r_baud_cnt <= '0;
                r_bit_idx  <= 3'd0;
            end else if (r_state != ST_IDLE) begin
                if (w_bit_end) begin
                    r_baud_cnt <= '0;
                    if (r_state == ST_DATA) begin
                        r_bit_idx <= (r_bit_idx == 3'd7) ? 3'd0 : r_bit_idx + 3'd1;
                    end
                end else begin
                    r_baud_cnt <= r_baud_cnt + CW'(1);
                end
            end
        end
    end

    // Next line level is decided one cycle ahead so uart_txd comes straight from a flop.
    always_comb begin
        w_state_next = r_state;
        w_txd_next   = r_txd;
        if (w_go) begin
            w_state_next = ST_START;
            w_txd_next   = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_next = ST_IDLE;
                    w_txd_next   = 1'b1;
                end
                ST_START: begin
                    if (w_bit_end) begin
                        w_state_next = ST_DATA;
                        w_txd_next   = r_data[0];
                    end else begin
                        w_txd_next   = 1'b0;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end && (r_bit_idx == 3'd7)) begin
                        w_state_next = ST_STOP;
                        w_txd_next   = 1'b1;
                    end else if (w_bit_end) begin
                        w_txd_next   = r_data[r_bit_idx + 3'd1];
                    end else begin
                        w_txd_next   = r_data[r_bit_idx];
                    end
                end
                ST_STOP: begin
                    w_txd_next = 1'b1;
                    if (w_bit_end) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_STOP;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_txd_next   = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_word_tx.sv
// 32-bit word transmitter: four 8N1 frames, most significant byte first,
// with an optional idle-high gap between the bytes of one word.
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = DEF_CLK_FREQ,
    parameter int BAUD_RATE    = DEF_BAUD_RATE,
    parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE),
    parameter int BYTE_GAP     = 0
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [31:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        uart_txd,
    output logic        tx_busy,
    output logic        tx_done
);

    localparam bit         HAS_GAP  = (BYTE_GAP > 0);
    localparam logic [9:0] GAP_LAST = 10'((BYTE_GAP > 0) ? BYTE_GAP - 1 : 0);

    // ST_START here means "a byte frame is on the line"; bit timing lives in uart_byte_tx.
    uart_state_t r_state;
    uart_state_t w_state_next;
    logic [31:0] r_shift;
    logic [1:0]  r_byte_idx;
    logic [9:0]  r_gap_cnt;
    logic        w_accept;
    logic        w_last_done;
    logic        w_byte_start;
    logic        w_byte_done;
    logic        w_byte_busy;
    logic [7:0]  w_byte_data;

    assign w_last_done = (r_state == ST_START) && w_byte_done && (r_byte_idx == 2'd3);
    assign tx_ready    = ((r_state == ST_IDLE) && !w_byte_busy) || w_last_done;
    assign tx_busy     = !tx_ready;
    assign tx_done     = w_last_done;
    assign w_accept    = tx_valid && tx_ready;

    uart_byte_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte_tx (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .i_start (w_byte_start),
        .i_data  (w_byte_data),
        .o_txd   (uart_txd),
        .o_busy  (w_byte_busy),
        .o_done  (w_byte_done)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= 32'h0000_0000;
            r_byte_idx <= 2'd0;
            r_gap_cnt  <= 10'd0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_shift    <= tx_data;
                r_byte_idx <= 2'd0;
                r_gap_cnt  <= 10'd0;
            end else if ((r_state == ST_START) && w_byte_done && (r_byte_idx != 2'd3)) begin
                r_shift    <= {r_shift[23:0], 8'h00};
                r_byte_idx <= r_byte_idx + 2'd1;
                r_gap_cnt  <= 10'd0;
            end else if (r_state == ST_GAP) begin
                r_gap_cnt  <= (r_gap_cnt == GAP_LAST) ? 10'd0 : r_gap_cnt + 10'd1;
            end
        end
    end

    // Without a gap the next byte starts on the same edge the shift register advances.
    always_comb begin
        w_state_next = r_state;
        w_byte_start = 1'b0;
        w_byte_data  = r_shift[31:24];
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_START;
                    w_byte_start = 1'b1;
                    w_byte_data  = tx_data[31:24];
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_START: begin
                if (w_byte_done && (r_byte_idx == 2'd3) && w_accept) begin
                    w_byte_start = 1'b1;
                    w_byte_data  = tx_data[31:24];
                end else if (w_byte_done && (r_byte_idx == 2'd3)) begin
                    w_state_next = ST_IDLE;
                end else if (w_byte_done && HAS_GAP) begin
                    w_state_next = ST_GAP;
                end else if (w_byte_done) begin
                    w_byte_start = 1'b1;
                    w_byte_data  = r_shift[23:16];
                end else begin
                    w_state_next = ST_START;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_next = ST_START;
                    w_byte_start = 1'b1;
                end else begin
                    w_state_next = ST_GAP;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: three instances (full-rate, fast, fast with byte gap)
// decoded by a mid-bit UART monitor feeding a byte scoreboard.
module tb_uart_word_tx;

    localparam int CA    = 434;
    localparam int CB    = 16;
    localparam int GAP_C = 100;

    typedef struct {
        logic [7:0] val;
        int         start;
        bit         ok;
    } rx_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [31:0] data_a = 32'h0, data_b = 32'h0, data_c = 32'h0;
    logic        valid_a = 1'b0, valid_b = 1'b0, valid_c = 1'b0;
    logic        txd_a, ready_a, busy_a, done_a;
    logic        txd_b, ready_b, busy_b, done_b;
    logic        txd_c, ready_c, busy_c, done_c;

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    rx_t        rx0[$], rx1[$], rx2[$];
    logic [7:0] exp0[$], exp1[$], exp2[$];
    int         done0[$], done1[$], done2[$];

    uart_word_tx u_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_data(data_a), .tx_valid(valid_a),
        .tx_ready(ready_a), .uart_txd(txd_a), .tx_busy(busy_a), .tx_done(done_a)
    );
    uart_word_tx #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .BYTE_GAP(0)) u_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_data(data_b), .tx_valid(valid_b),
        .tx_ready(ready_b), .uart_txd(txd_b), .tx_busy(busy_b), .tx_done(done_b)
    );
    uart_word_tx #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .BYTE_GAP(GAP_C)) u_c (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_data(data_c), .tx_valid(valid_c),
        .tx_ready(ready_c), .uart_txd(txd_c), .tx_busy(busy_c), .tx_done(done_c)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic logic line(input int k);
        case (k)
            0:       return txd_a;
            1:       return txd_b;
            default: return txd_c;
        endcase
    endfunction

    function automatic logic rdy(input int k);
        case (k)
            0:       return ready_a;
            1:       return ready_b;
            default: return ready_c;
        endcase
    endfunction

    function automatic int rx_count(input int k);
        case (k)
            0:       return rx0.size();
            1:       return rx1.size();
            default: return rx2.size();
        endcase
    endfunction

    function automatic rx_t pop_rx(input int k);
        case (k)
            0:       return rx0.pop_front();
            1:       return rx1.pop_front();
            default: return rx2.pop_front();
        endcase
    endfunction

    function automatic logic [7:0] pop_exp(input int k);
        case (k)
            0:       return exp0.pop_front();
            1:       return exp1.pop_front();
            default: return exp2.pop_front();
        endcase
    endfunction

    task automatic push_word(input int k, input logic [31:0] w);
        for (int i = 3; i >= 0; i--) begin
            case (k)
                0:       exp0.push_back(w[8*i +: 8]);
                1:       exp1.push_back(w[8*i +: 8]);
                default: exp2.push_back(w[8*i +: 8]);
            endcase
        end
    endtask

    task automatic set_in(input int k, input logic v, input logic [31:0] d);
        case (k)
            0:       begin valid_a = v; data_a = d; end
            1:       begin valid_b = v; data_b = d; end
            default: begin valid_c = v; data_c = d; end
        endcase
    endtask

    // Mid-bit decoder; also flags any level change inside a bit period.
    task automatic mon(input int k, input int c);
        rx_t  r;
        logic v;
        logic first;
        bit   ab;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst && line(k) === 1'b0) begin
                r.start = cyc; r.ok = 1'b1; r.val = 8'h00; ab = 1'b0; first = 1'b0;
                for (int b = 0; b < 10 && !ab; b++) begin
                    for (int j = 0; j < c && !ab; j++) begin
                        if (b != 0 || j != 0) @(negedge sys_clk);
                        if (sys_rst) begin
                            ab = 1'b1;
                        end else begin
                            v = line(k);
                            if (j == 0) first = v;
                            else if (v !== first) r.ok = 1'b0;
                            if (b == 0 && v !== 1'b0) r.ok = 1'b0;
                            if (b == 9 && v !== 1'b1) r.ok = 1'b0;
                            if (b >= 1 && b <= 8 && j == c / 2) r.val[b-1] = v;
                        end
                    end
                end
                if (!ab) begin
                    case (k)
                        0:       rx0.push_back(r);
                        1:       rx1.push_back(r);
                        default: rx2.push_back(r);
                    endcase
                end
            end
        end
    endtask

    always begin mon(0, CA); end
    always begin mon(1, CB); end
    always begin mon(2, CB); end

    always @(negedge sys_clk) begin
        if (done_a === 1'b1) done0.push_back(cyc);
        if (done_b === 1'b1) done1.push_back(cyc);
        if (done_c === 1'b1) done2.push_back(cyc);
    end

    task automatic send(input int k, input logic [31:0] w, output int acc);
        acc = -1;
        set_in(k, 1'b1, w);
        for (int n = 0; n < 200 && acc < 0; n++) begin
            if (n > 0) @(negedge sys_clk);
            if (rdy(k) === 1'b1) acc = cyc;
        end
        push_word(k, w);
        @(negedge sys_clk);
        set_in(k, 1'b0, 32'h0);
    endtask

    task automatic wait_rx(input int k, input int n, input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge sys_clk);
            if (rx_count(k) >= n) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        int acc;
        bit hi_bad;
        repeat (3) @(negedge sys_clk);
        total++; if (txd_b !== 1'b1)  begin bad++; $display("FAIL rst_txd: got %b want 1", txd_b); end
        total++; if (ready_b !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", ready_b); end
        total++; if (busy_b !== 1'b0)  begin bad++; $display("FAIL rst_busy: got %b want 0", busy_b); end
        total++; if (done_b !== 1'b0)  begin bad++; $display("FAIL rst_done: got %b want 0", done_b); end
        total++; if (txd_a !== 1'b1 || txd_c !== 1'b1) begin
            bad++; $display("FAIL rst_txd_ac: got %b%b want 11", txd_a, txd_c);
        end
        sys_rst = 1'b0;
        @(negedge sys_clk);
        send(1, 32'h5A5A5A5A, acc);
        exp1.delete();
        repeat (4 * CB) @(negedge sys_clk);
        total++; if (busy_b !== 1'b1) begin bad++; $display("FAIL rst_mid_busy: got %b want 1", busy_b); end
        #1 sys_rst = 1'b1;
        #1;
        total++; if (txd_b !== 1'b1)  begin bad++; $display("FAIL rst_async_txd: got %b want 1", txd_b); end
        total++; if (ready_b !== 1'b1) begin bad++; $display("FAIL rst_async_ready: got %b want 1", ready_b); end
        total++; if (busy_b !== 1'b0)  begin bad++; $display("FAIL rst_async_busy: got %b want 0", busy_b); end
        @(negedge sys_clk);
        sys_rst = 1'b0;
        hi_bad = 1'b0;
        for (int i = 0; i < 20 * CB; i++) begin
            @(negedge sys_clk);
            if (txd_b !== 1'b1) hi_bad = 1'b1;
        end
        total++; if (hi_bad) begin bad++; $display("FAIL rst_no_resume: line left idle, want steady 1"); end
        total++; if (rx1.size() != 0) begin bad++; $display("FAIL rst_no_frame: got %0d frames want 0", rx1.size()); end
        total++; if (done1.size() != 0) begin bad++; $display("FAIL rst_no_done: got %0d pulses want 0", done1.size()); end
    endtask

    task automatic test_single_word();
        int acc, d;
        bit got;
        rx_t r;
        logic [7:0] e;
        int s[4];
        send(0, 32'h12345678, acc);
        total++; if (acc < 0) begin bad++; $display("FAIL single_accept: got no handshake want one"); end
        wait_rx(0, 4, 45 * CA, got);
        total++;
        if (!got) begin
            bad++; $display("FAIL single_rx_count: got %0d bytes want 4", rx_count(0));
        end else begin
            for (int i = 0; i < 4; i++) begin
                r = pop_rx(0); e = pop_exp(0); s[i] = r.start;
                total++; if (r.val !== e) begin bad++; $display("FAIL single_byte%0d: got %02h want %02h", i, r.val, e); end
                total++; if (r.ok !== 1'b1) begin bad++; $display("FAIL single_frame%0d: got bad framing want clean", i); end
            end
            total++; if (s[0] != acc + 1) begin bad++; $display("FAIL single_latency: got start %0d want %0d", s[0], acc + 1); end
            for (int i = 1; i < 4; i++) begin
                total++;
                if (s[i] - s[i-1] != 10 * CA) begin
                    bad++; $display("FAIL single_spacing%0d: got %0d want %0d", i, s[i] - s[i-1], 10 * CA);
                end
            end
            repeat (3) @(negedge sys_clk);
            total++;
            if (done0.size() != 1) begin
                bad++; $display("FAIL single_done_count: got %0d want 1", done0.size());
            end else begin
                d = done0.pop_front();
                total++; if (d - s[0] + 1 != 40 * CA) begin bad++; $display("FAIL single_duration: got %0d want %0d", d - s[0] + 1, 40 * CA); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc1, acc2, d;
        logic dn;
        bit got;
        rx_t r;
        logic [7:0] e;
        int s[8];
        acc1 = -1; acc2 = -1; dn = 1'b0;
        set_in(1, 1'b1, 32'hA5A5A5A5);
        for (int n = 0; n < 200 && acc1 < 0; n++) begin
            if (n > 0) @(negedge sys_clk);
            if (ready_b === 1'b1) acc1 = cyc;
        end
        push_word(1, 32'hA5A5A5A5);
        @(negedge sys_clk);
        set_in(1, 1'b1, 32'h00FF00FF);
        for (int n = 0; n < 50 * CB && acc2 < 0; n++) begin
            if (n > 0) @(negedge sys_clk);
            if (ready_b === 1'b1) begin acc2 = cyc; dn = done_b; end
        end
        push_word(1, 32'h00FF00FF);
        @(negedge sys_clk);
        set_in(1, 1'b0, 32'h0);
        total++; if (acc1 < 0 || acc2 < 0) begin bad++; $display("FAIL b2b_accept: got %0d/%0d want both >= 0", acc1, acc2); end
        total++; if (dn !== 1'b1) begin bad++; $display("FAIL b2b_accept_in_done: got done=%b want 1", dn); end
        wait_rx(1, 8, 100 * CB, got);
        total++;
        if (!got) begin
            bad++; $display("FAIL b2b_rx_count: got %0d bytes want 8", rx_count(1));
        end else begin
            for (int i = 0; i < 8; i++) begin
                r = pop_rx(1); e = pop_exp(1); s[i] = r.start;
                total++; if (r.val !== e) begin bad++; $display("FAIL b2b_byte%0d: got %02h want %02h", i, r.val, e); end
                total++; if (r.ok !== 1'b1) begin bad++; $display("FAIL b2b_frame%0d: got bad framing want clean", i); end
            end
            total++; if (s[4] - s[3] != 10 * CB) begin bad++; $display("FAIL b2b_no_idle: got %0d want %0d", s[4] - s[3], 10 * CB); end
            total++; if (s[4] != acc2 + 1) begin bad++; $display("FAIL b2b_latency: got %0d want %0d", s[4], acc2 + 1); end
            repeat (3) @(negedge sys_clk);
            total++;
            if (done1.size() != 2) begin
                bad++; $display("FAIL b2b_done_count: got %0d want 2", done1.size());
            end else begin
                d = done1.pop_front();
                total++; if (d != acc2) begin bad++; $display("FAIL b2b_done_cycle: got %0d want %0d", d, acc2); end
                done1.delete();
            end
        end
    endtask

    task automatic test_ignore_busy();
        int acc, acc2;
        logic dn;
        bit got;
        rx_t r;
        logic [7:0] e;
        send(1, 32'hCAFEBABE, acc);
        wait_rx(1, 1, 20 * CB, got);
        repeat (CB) @(negedge sys_clk);
        acc2 = -1; dn = 1'b0;
        set_in(1, 1'b1, 32'hFFFFFFFF);
        for (int n = 0; n < 50 * CB && acc2 < 0; n++) begin
            if (n > 0) @(negedge sys_clk);
            if (ready_b === 1'b1) begin acc2 = cyc; dn = done_b; end
        end
        push_word(1, 32'hFFFFFFFF);
        @(negedge sys_clk);
        set_in(1, 1'b0, 32'h0);
        total++; if (acc2 != acc + 40 * CB) begin bad++; $display("FAIL busy_accept_cycle: got %0d want %0d", acc2, acc + 40 * CB); end
        total++; if (dn !== 1'b1) begin bad++; $display("FAIL busy_accept_in_done: got done=%b want 1", dn); end
        wait_rx(1, 8, 100 * CB, got);
        total++;
        if (!got) begin
            bad++; $display("FAIL busy_rx_count: got %0d bytes want 8", rx_count(1));
        end else begin
            for (int i = 0; i < 8; i++) begin
                r = pop_rx(1); e = pop_exp(1);
                total++; if (r.val !== e) begin bad++; $display("FAIL busy_byte%0d: got %02h want %02h", i, r.val, e); end
                total++; if (r.ok !== 1'b1) begin bad++; $display("FAIL busy_frame%0d: got bad framing want clean", i); end
            end
        end
        repeat (3) @(negedge sys_clk);
        done1.delete();
    endtask

    task automatic test_gap();
        int acc, d;
        bit got;
        rx_t r;
        logic [7:0] e;
        int s[4];
        send(2, 32'h01020304, acc);
        wait_rx(2, 4, 45 * CB + 3 * GAP_C, got);
        total++;
        if (!got) begin
            bad++; $display("FAIL gap_rx_count: got %0d bytes want 4", rx_count(2));
        end else begin
            for (int i = 0; i < 4; i++) begin
                r = pop_rx(2); e = pop_exp(2); s[i] = r.start;
                total++; if (r.val !== e) begin bad++; $display("FAIL gap_byte%0d: got %02h want %02h", i, r.val, e); end
                total++; if (r.ok !== 1'b1) begin bad++; $display("FAIL gap_frame%0d: got bad framing want clean", i); end
            end
            total++; if (s[0] != acc + 1) begin bad++; $display("FAIL gap_latency: got %0d want %0d", s[0], acc + 1); end
            for (int i = 1; i < 4; i++) begin
                total++;
                if (s[i] - s[i-1] != 10 * CB + GAP_C) begin
                    bad++; $display("FAIL gap_spacing%0d: got %0d want %0d", i, s[i] - s[i-1], 10 * CB + GAP_C);
                end
            end
            repeat (3) @(negedge sys_clk);
            total++;
            if (done2.size() != 1) begin
                bad++; $display("FAIL gap_done_count: got %0d want 1", done2.size());
            end else begin
                d = done2.pop_front();
                total++;
                if (d - s[0] + 1 != 40 * CB + 3 * GAP_C) begin
                    bad++; $display("FAIL gap_duration: got %0d want %0d", d - s[0] + 1, 40 * CB + 3 * GAP_C);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_ignore_busy();
        test_gap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
